// File: rtl/attack_map_gather.sv
// rtl/attack_map_gather.sv - gathers 128 per-square attack results into maps, check flags and castling safety
// Optional: ATTACK_MAP_CASTLE_EN enables castle_safe; otherwise it is tied to zero.
`ifndef EMPTY_POSN
`define EMPTY_POSN 4'd0
`endif
`ifndef WHITE_KING
`define WHITE_KING 4'd6
`endif
`ifndef BLACK_KING
`define BLACK_KING 4'd14
`endif

module attack_map_gather #(
    parameter int PIECE_WIDTH = 4,
    parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH = SIDE_WIDTH * 8,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   board_valid,
    input  logic [63:0]            w_attacked,
    input  logic [63:0]            w_attacked_valid,
    input  logic [63:0]            b_attacked,
    input  logic [63:0]            b_attacked_valid,
    output logic [63:0]            white_map,
    output logic [63:0]            black_map,
    output logic                   white_in_check,
    output logic                   black_in_check,
    output logic [3:0]             castle_safe,
    output logic                   king_error,
    output logic                   timeout_error,
    output logic                   busy,
    output logic                   result_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, COLLECT, EVAL} state_t;

    state_t                 state, state_nx;
    logic [BOARD_WIDTH-1:0] board_q;
    logic [63:0]            w_acc_v, b_acc_v, w_acc_d, b_acc_d;
    logic [63:0]            w_v_nx, b_v_nx;
    logic [CW-1:0]          count;
    logic                   timeout_pend;
    logic [5:0]             wk_idx, bk_idx, wk_idx_nx, bk_idx_nx;
    logic                   wking_ok, bking_ok;
    logic [6:0]             wk_cnt, bk_cnt;
    logic                   all_in;

    always_comb begin
        wk_idx_nx = '0;
        bk_idx_nx = '0;
        wk_cnt    = '0;
        bk_cnt    = '0;
        for (int n = 0; n < 64; n++) begin
            if (board_q[(n / 8) * SIDE_WIDTH + (n % 8) * PIECE_WIDTH +: PIECE_WIDTH] == PIECE_WIDTH'(`WHITE_KING)) begin
                wk_idx_nx = 6'(n);
                wk_cnt    = wk_cnt + 7'd1;
            end
            if (board_q[(n / 8) * SIDE_WIDTH + (n % 8) * PIECE_WIDTH +: PIECE_WIDTH] == PIECE_WIDTH'(`BLACK_KING)) begin
                bk_idx_nx = 6'(n);
                bk_cnt    = bk_cnt + 7'd1;
            end
        end
    end

    // Completion includes squares arriving this very cycle.
    assign w_v_nx = w_acc_v | w_attacked_valid;
    assign b_v_nx = b_acc_v | b_attacked_valid;
    assign all_in = (&w_v_nx) & (&b_v_nx);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (board_valid) state_nx = SCAN;
            SCAN:    state_nx = all_in ? EVAL : COLLECT;
            COLLECT: if (all_in || count == CW'(1)) state_nx = EVAL;
            EVAL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            board_q        <= '0;
            w_acc_v        <= '0;
            b_acc_v        <= '0;
            w_acc_d        <= '0;
            b_acc_d        <= '0;
            count          <= '0;
            timeout_pend   <= 1'b0;
            wk_idx         <= '0;
            bk_idx         <= '0;
            wking_ok       <= 1'b0;
            bking_ok       <= 1'b0;
            white_map      <= '0;
            black_map      <= '0;
            white_in_check <= 1'b0;
            black_in_check <= 1'b0;
            king_error     <= 1'b0;
            timeout_error  <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            state        <= state_nx;
            result_valid <= 1'b0;
            case (state)
                IDLE: if (board_valid) begin
                    board_q      <= board;
                    w_acc_v      <= '0;
                    b_acc_v      <= '0;
                    w_acc_d      <= '0;
                    b_acc_d      <= '0;
                    count        <= CW'(TIMEOUT);
                    timeout_pend <= 1'b0;
                end
                SCAN, COLLECT: begin
                    // First valid wins: only squares not yet captured take a value.
                    w_acc_v <= w_v_nx;
                    b_acc_v <= b_v_nx;
                    w_acc_d <= w_acc_d | (w_attacked & w_attacked_valid & ~w_acc_v);
                    b_acc_d <= b_acc_d | (b_attacked & b_attacked_valid & ~b_acc_v);
                    if (state == SCAN) begin
                        wk_idx   <= wk_idx_nx;
                        bk_idx   <= bk_idx_nx;
                        wking_ok <= (wk_cnt == 7'd1);
                        bking_ok <= (bk_cnt == 7'd1);
                    end else begin
                        count <= count - CW'(1);
                        if (!all_in && count == CW'(1)) timeout_pend <= 1'b1;
                    end
                end
                EVAL: begin
                    white_map      <= w_acc_d;
                    black_map      <= b_acc_d;
                    white_in_check <= wking_ok & b_acc_d[wk_idx];
                    black_in_check <= bking_ok & w_acc_d[bk_idx];
                    king_error     <= ~wking_ok | ~bking_ok;
                    timeout_error  <= timeout_pend;
                    result_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ATTACK_MAP_CASTLE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            castle_safe <= '0;
        end else if (state == EVAL) begin
            castle_safe <= {~|w_acc_d[60:58], ~|w_acc_d[62:60], ~|b_acc_d[4:2], ~|b_acc_d[6:4]};
        end
    end
`else
    assign castle_safe = 4'b0000;
`endif

endmodule
